high_score_table: RTL and testbench

- Parametrised successor to the per-user high-score block.
- Stores each user's best BCD score in an internal synchronous-read array of 2**USER_AW entries, and tracks the global best score and which user holds it.
- On a commit it reads the user's entry, compares, writes back if the new score is higher, and updates the global record.
- Sits between the auth/address logic, the game timer/score counters and the seven-segment display mux.

---
 rtl/high_score_table.sv | 139 +++++++++++++
 tb/tb_high_score_table.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/high_score_table.sv
// Per-user best BCD score table with global best tracking; commit = read, compare, conditional write.
// Optional HS_LOOKUP_EN adds a read-only lookup request with the same latency as a commit.
module high_score_table #(
  parameter int USER_AW = 6,
  parameter int DIGITS  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [USER_AW-1:0]   user_addr,
  input  logic [4*DIGITS-1:0]  score_bcd,
  input  logic                 commit,
`ifdef HS_LOOKUP_EN
  input  logic                 lookup,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 new_personal,
  output logic                 global_high_signal,
  output logic [4*DIGITS-1:0]  display_bcd,
  output logic [4*DIGITS-1:0]  global_score_bcd,
  output logic [USER_AW-1:0]   global_holder
);
  localparam int NUM_USERS = 1 << USER_AW;
  localparam int SW = 4 * DIGITS;

  typedef enum logic [2:0] {CLEAR, IDLE, READ, CMP, DONE} state_t;

  state_t             state, nextState;
  logic [SW-1:0]      mem [NUM_USERS];
  logic [USER_AW-1:0] clrCnt;
  logic [USER_AW-1:0] addrQ;
  logic [SW-1:0]      scoreQ;
  logic [SW-1:0]      rdData;
  logic               isLookup;
  logic               doneQ;
  logic               lookupReq;
  logic               accept;
  logic               newBeatsPersonal;
  logic               newBeatsGlobal;
  logic               memWe;
  logic [USER_AW-1:0] memWAddr;
  logic [SW-1:0]      memWData;

`ifdef HS_LOOKUP_EN
  assign lookupReq = lookup;
`else
  assign lookupReq = 1'b0;
`endif

  function automatic logic [SW-1:0] clampBcd(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // The done pulse is registered, so busy must also cover the cycle it is high.
  assign busy   = (state != IDLE) || doneQ;
  assign done   = doneQ;
  assign accept = (state == IDLE) && !doneQ && (commit || lookupReq);

  // Packed BCD with digits 0..9 orders the same as its decimal value.
  assign newBeatsPersonal = scoreQ > rdData;
  assign newBeatsGlobal   = scoreQ > global_score_bcd;

  always_comb begin
    nextState = state;
    case (state)
      CLEAR:   if (clrCnt == USER_AW'(NUM_USERS - 1)) nextState = IDLE;
      IDLE:    if (accept) nextState = READ;
      READ:    nextState = CMP;
      CMP:     nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = CLEAR;
    endcase
  end

  always_comb begin
    memWe    = 1'b0;
    memWAddr = addrQ;
    memWData = scoreQ;
    if (!rst) begin
      if (state == CLEAR) begin
        memWe    = 1'b1;
        memWAddr = clrCnt;
        memWData = '0;
      end else if (state == CMP && !isLookup && newBeatsPersonal) begin
        memWe = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) mem[memWAddr] <= memWData;
    rdData <= mem[addrQ];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= CLEAR;
      clrCnt             <= '0;
      addrQ              <= '0;
      scoreQ             <= '0;
      isLookup           <= 1'b0;
      doneQ              <= 1'b0;
      new_personal       <= 1'b0;
      global_high_signal <= 1'b0;
      display_bcd        <= '0;
      global_score_bcd   <= '0;
      global_holder      <= '0;
    end else begin
      state <= nextState;
      doneQ <= (state == DONE);
      if (state == CLEAR) clrCnt <= clrCnt + 1'b1;
      if (accept) begin
        addrQ    <= user_addr;
        scoreQ   <= clampBcd(score_bcd);
        isLookup <= !commit;
      end
      if (state == CMP) begin
        if (isLookup) begin
          new_personal       <= 1'b0;
          display_bcd        <= rdData;
          global_high_signal <= (addrQ == global_holder) && (global_score_bcd != '0);
        end else begin
          new_personal <= newBeatsPersonal;
          display_bcd  <= newBeatsPersonal ? scoreQ : rdData;
          global_high_signal <= newBeatsGlobal;
          if (newBeatsGlobal) begin
            global_score_bcd <= scoreQ;
            global_holder    <= addrQ;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_high_score_table.sv
// Randomized and directed bench for high_score_table against a decimal-value reference model.
module tb_high_score_table;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] userAddr = '0;
  logic [7:0] scoreBcd = '0;
  logic       commit = 1'b0;
  logic       lookup = 1'b0;
  logic       busy, done, newPersonal, globalHighSignal;
  logic [7:0] displayBcd, globalScoreBcd;
  logic [5:0] globalHolder;

  int checks = 0;
  int failures = 0;

  logic [7:0] mTable [64];
  logic [7:0] mGScore, mDisp;
  int         mGHolder;
  bit         mNp, mGhs;

  always #5 clk = ~clk;

  high_score_table #(.USER_AW(6), .DIGITS(2)) dut (
    .clk(clk), .rst(rst), .user_addr(userAddr), .score_bcd(scoreBcd), .commit(commit),
`ifdef HS_LOOKUP_EN
    .lookup(lookup),
`endif
    .busy(busy), .done(done), .new_personal(newPersonal), .global_high_signal(globalHighSignal),
    .display_bcd(displayBcd), .global_score_bcd(globalScoreBcd), .global_holder(globalHolder)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bcdVal(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] clampM(input logic [7:0] b);
    logic [3:0] hi, lo;
    hi = (b[7:4] > 4'd9) ? 4'd9 : b[7:4];
    lo = (b[3:0] > 4'd9) ? 4'd9 : b[3:0];
    return {hi, lo};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 64; i++) mTable[i] = 8'h00;
    mGScore = 8'h00; mGHolder = 0; mDisp = 8'h00; mNp = 0; mGhs = 0;
  endtask

  task automatic modelCommit(input int addr, input logic [7:0] score);
    logic [7:0] s;
    s = clampM(score);
    if (bcdVal(s) > bcdVal(mTable[addr])) begin
      mTable[addr] = s; mNp = 1; mDisp = s;
    end else begin
      mNp = 0; mDisp = mTable[addr];
    end
    if (bcdVal(s) > bcdVal(mGScore)) begin
      mGScore = s; mGHolder = addr; mGhs = 1;
    end else begin
      mGhs = 0;
    end
  endtask

  task automatic modelLookup(input int addr);
    mDisp = mTable[addr];
    mNp = 0;
    mGhs = (addr == mGHolder) && (mGScore != 8'h00);
  endtask

  task automatic checkOutputs(input string tag);
    chk({tag, "_np"}, 32'(newPersonal), 32'(mNp));
    chk({tag, "_ghs"}, 32'(globalHighSignal), 32'(mGhs));
    chk({tag, "_disp"}, 32'(displayBcd), 32'(mDisp));
    chk({tag, "_gscore"}, 32'(globalScoreBcd), 32'(mGScore));
    chk({tag, "_holder"}, 32'(globalHolder), 32'(mGHolder));
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // mode: 0 = commit, 1 = lookup, 2 = commit and lookup together
  task automatic runOp(input string tag, input int addr, input logic [7:0] score,
                       input int mode, input bit injectBusy);
    int firstK = 0;
    int pulses = 0;
    waitIdle();
    userAddr = 6'(addr);
    scoreBcd = score;
    commit   = (mode != 1);
    lookup   = (mode != 0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (firstK == 0) firstK = k;
      end
      if (k == 1) begin
        commit = 1'b0;
        lookup = 1'b0;
      end
      if (injectBusy && k == 2) begin
        userAddr = 6'(addr + 1);
        scoreBcd = 8'h99;
        commit = 1'b1;
      end
      if (k == 3) commit = 1'b0;
    end
    chk({tag, "_latency"}, 32'(firstK), 32'd4);
    chk({tag, "_pulses"}, 32'(pulses), 32'd1);
    if (mode == 1) modelLookup(addr);
    else modelCommit(addr, score);
    checkOutputs(tag);
  endtask

  initial begin
    int busyCnt, doneSeen, n, mode, addr;
    modelReset();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    checkOutputs("rst");

    // Release reset with commit held high: the clear sweep must ignore it.
    rst = 1'b0; commit = 1'b1; userAddr = 6'd0; scoreBcd = 8'h00;
    busyCnt = 0; doneSeen = 0; n = 0;
    while (busy && n < 100) begin
      busyCnt++;
      @(negedge clk);
      if (done) doneSeen++;
      n++;
    end
    chk("clear_busy_cycles", 32'(busyCnt), 32'd64);
    chk("clear_done", 32'(doneSeen), 32'd0);
    chk("clear_end_done", 32'(done), 32'd0);
    checkOutputs("clear_end");
    @(negedge clk);
    commit = 1'b0;
    n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("held_commit_done", 32'(done), 32'd1);
    modelCommit(0, 8'h00);
    checkOutputs("zero_empty");

    runOp("c5_42", 5, 8'h42, 0, 0);
    runOp("c5_37", 5, 8'h37, 0, 0);
    runOp("c9_tie", 9, 8'h42, 0, 0);
    runOp("c3_clamp", 3, 8'hA5, 0, 1);
    runOp("c7_max", 7, 8'h99, 0, 0);
    runOp("c7_maxtie", 7, 8'hFF, 0, 0);

    // Reset while the commit is in READ: no done, table and globals cleared.
    waitIdle();
    userAddr = 6'd3; scoreBcd = 8'h99; commit = 1'b1;
    @(negedge clk);
    commit = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    doneSeen = 0; n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      if (done) doneSeen++;
      n++;
    end
    chk("abort_done", 32'(doneSeen), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    modelReset();
    checkOutputs("abort");
    runOp("after_abort", 3, 8'h12, 0, 0);
    runOp("c3_clamp2", 3, 8'hA5, 0, 0);

`ifdef HS_LOOKUP_EN
    runOp("look3", 3, 8'h00, 1, 0);
    chk("look3_disp_const", 32'(displayBcd), 32'h95);
    runOp("look5", 5, 8'h00, 1, 0);
    runOp("both", 5, 8'h61, 2, 0);
    runOp("look5b", 5, 8'h00, 1, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      addr = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63));
`ifdef HS_LOOKUP_EN
      mode = int'($urandom_range(0, 2));
`else
      mode = 0;
`endif
      runOp("rand", addr, 8'($urandom), mode, ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
